debounce_pulser: RTL and testbench

Conditions a raw, bouncing pushbutton into a clean debounced level and a single-cycle count-enable pulse, with optional hold-to-repeat. It sits directly upstream of the 10-bit enabled counter: its `C` output drives the counter's count-enable input, and both share `CLK`. Each accepted press, and each auto-repeat tick, advances the counter by exactly one.

---
 rtl/debounce_pulser_if.sv | 14 +
 rtl/debounce_pulser.sv | 127 ++++++++++++
 tb/tb_debounce_pulser.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_pulser_if.sv
// Button-side bundle for debounce_pulser: raw button in, debounced level and
// count-enable strobe out, plus the FSM state for observation.
`timescale 1ns/1ps
interface debounce_pulser_if;
  // C is a one-cycle strobe with no backpressure: the consumer takes it on the
  // edge it is high and there is no ready; B has no valid, it is sampled every cycle.
  logic       B;
  logic       C;
  logic       PRESSED;
  logic [1:0] dbg_state;

  modport master (output B, input C, input PRESSED, input dbg_state);
  modport slave  (input B, output C, output PRESSED, output dbg_state);
endinterface

// File: rtl/debounce_pulser.sv
// Pushbutton conditioner: 2-flop sync, stable-count debounce, and a press /
// hold / repeat FSM producing single-cycle count-enable pulses.
`timescale 1ns/1ps
module debounce_pulser #(
  parameter int DEB_CYCLES = 16,
  parameter int REP_EN     = 1,
  parameter int REP_DELAY  = 64,
  parameter int REP_PERIOD = 16
) (
  input  logic               CLK,
  input  logic               CLR,
  debounce_pulser_if.slave   bus
);

  localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW   = $clog2(RMAX);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REP_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic          s1, s;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic          pressed_q, pressed_nxt;
  logic          press_ev, release_ev;
  state_t        state, state_nxt;
  logic [RW-1:0] rtim, rtim_nxt;
  logic          c_q, c_nxt;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= bus.B;
      s  <= s1;
    end
  end

  // Any cycle where s agrees with the current level restarts the count.
  always_comb begin
    pressed_nxt = pressed_q;
    dcnt_nxt    = dcnt;
    if (s == pressed_q) begin
      dcnt_nxt = '0;
    end else if (dcnt == DEB_LAST) begin
      pressed_nxt = s;
      dcnt_nxt    = '0;
    end else begin
      dcnt_nxt = dcnt + DW'(1);
    end
  end

  // Events come from the next-state so C lines up with PRESSED rising.
  assign press_ev   = !pressed_q &&  pressed_nxt;
  assign release_ev =  pressed_q && !pressed_nxt;

  always_comb begin
    state_nxt = state;
    rtim_nxt  = rtim;
    c_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (press_ev) begin
          c_nxt     = 1'b1;
          rtim_nxt  = '0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (release_ev) begin
          rtim_nxt  = '0;
          state_nxt = IDLE;
        end else if ((REP_EN != 0) && (rtim == DELAY_LAST)) begin
          c_nxt     = 1'b1;
          rtim_nxt  = '0;
          state_nxt = REPEAT;
        end else if (rtim != '1) begin
          rtim_nxt = rtim + RW'(1);
        end
      end
      REPEAT: begin
        if (release_ev) begin
          rtim_nxt  = '0;
          state_nxt = IDLE;
        end else if (rtim == PERIOD_LAST) begin
          c_nxt    = 1'b1;
          rtim_nxt = '0;
        end else begin
          rtim_nxt = rtim + RW'(1);
        end
      end
      default: begin
        rtim_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      dcnt      <= '0;
      pressed_q <= 1'b0;
      state     <= IDLE;
      rtim      <= '0;
      c_q       <= 1'b0;
    end else begin
      dcnt      <= dcnt_nxt;
      pressed_q <= pressed_nxt;
      state     <= state_nxt;
      rtim      <= rtim_nxt;
      c_q       <= c_nxt;
    end
  end

  assign bus.C         = c_q;
  assign bus.PRESSED   = pressed_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_debounce_pulser.sv
// Bench for debounce_pulser: one repeating and one non-repeating instance share
// the raw button; expected pulse edges are queued at stimulus time.
`timescale 1ns/1ps
module tb_debounce_pulser;

  localparam int DEB        = 4;
  localparam int REP_DELAY  = 8;
  localparam int REP_PERIOD = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic b_raw = 1'b0;
  int   edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  debounce_pulser_if if_a ();
  debounce_pulser_if if_b ();
  assign if_a.B = b_raw;
  assign if_b.B = b_raw;

  debounce_pulser #(.DEB_CYCLES(DEB), .REP_EN(1), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD))
    dut_a (.CLK(clk), .CLR(rst_n), .bus(if_a));
  debounce_pulser #(.DEB_CYCLES(DEB), .REP_EN(0), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD))
    dut_b (.CLK(clk), .CLR(rst_n), .bus(if_b));

  // ---------------- scoreboard ----------------
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [9:0]  cnt_a = '0;
  logic [9:0]  cnt_b = '0;
  logic        c_prev_a = 1'b0, c_prev_b = 1'b0, p_prev_a = 1'b0;
  int          tog_a = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pulses are identified by the posedge count after which C is seen high.
  always @(negedge clk) begin
    if (if_a.C) begin
      check("a_c_gap", {31'd0, c_prev_a}, 0);
      check("a_c_expected", {31'd0, exp_a_q.size() != 0}, 1);
      if (exp_a_q.size() != 0) check("a_c_edge", edge_cnt, exp_a_q.pop_front());
      cnt_a = cnt_a + 10'd1;
    end
    if (if_b.C) begin
      check("b_c_gap", {31'd0, c_prev_b}, 0);
      check("b_c_expected", {31'd0, exp_b_q.size() != 0}, 1);
      if (exp_b_q.size() != 0) check("b_c_edge", edge_cnt, exp_b_q.pop_front());
      cnt_b = cnt_b + 10'd1;
    end
    if (if_a.PRESSED !== p_prev_a) tog_a++;
    c_prev_a = if_a.C;
    c_prev_b = if_b.C;
    p_prev_a = if_a.PRESSED;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cnt(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  // Press pulse at pabs; repeats at pabs+DELAY+k*PERIOD strictly before release edge rabs.
  task automatic expect_burst(input int pabs, input int rabs, output int na);
    int t;
    na = 1;
    exp_a_q.push_back(pabs);
    exp_b_q.push_back(pabs);
    t = pabs + REP_DELAY;
    while (t < rabs) begin
      exp_a_q.push_back(t);
      na++;
      t += REP_PERIOD;
    end
  endtask

  task automatic finish_scn(input string tag, input int rabs, input int na, input int nb,
                            input logic [9:0] ca0, input logic [9:0] cb0);
    logic [9:0] da, db;
    wait_cnt(rabs - 1);
    check({tag, "_pressed_before_rel"}, {31'd0, if_a.PRESSED}, 1);
    wait_cnt(rabs);
    check({tag, "_pressed_a_rel"}, {31'd0, if_a.PRESSED}, 0);
    check({tag, "_pressed_b_rel"}, {31'd0, if_b.PRESSED}, 0);
    check({tag, "_state_a_idle"}, {30'd0, if_a.dbg_state}, 0);
    check({tag, "_state_b_idle"}, {30'd0, if_b.dbg_state}, 0);
    wait_cnt(rabs + 3);
    check({tag, "_q_a_empty"}, exp_a_q.size(), 0);
    check({tag, "_q_b_empty"}, exp_b_q.size(), 0);
    da = cnt_a - ca0;
    db = cnt_b - cb0;
    check({tag, "_count_a"}, {22'd0, da}, na);
    check({tag, "_count_b"}, {22'd0, db}, nb);
  endtask

  // Clean press: B high for hi edges (0..hi-1), low afterwards.
  task automatic run_hold(input string tag, input int hi);
    int t0, pabs, rabs, na;
    logic [9:0] ca0, cb0;
    ca0 = cnt_a;
    cb0 = cnt_b;
    @(negedge clk);
    t0    = edge_cnt;
    b_raw = 1'b1;
    pabs  = t0 + DEB + 2;
    rabs  = t0 + hi + DEB + 2;
    expect_burst(pabs, rabs, na);
    wait_cnt(pabs - 1);
    check({tag, "_pressed_pre"}, {31'd0, if_a.PRESSED}, 0);
    wait_cnt(pabs);
    check({tag, "_pressed_p"}, {31'd0, if_a.PRESSED}, 1);
    wait_cnt(t0 + hi);
    check({tag, "_state_b_hold"}, {30'd0, if_b.dbg_state}, 1);
    b_raw = 1'b0;
    finish_scn(tag, rabs, na, 1, ca0, cb0);
  endtask

  task automatic run_bounce();
    int t0, pabs, rabs, na;
    logic [9:0] ca0, cb0;
    logic [9:0] pat;
    pat = 10'b1110110111;
    ca0 = cnt_a;
    cb0 = cnt_b;
    @(negedge clk);
    t0    = edge_cnt;
    tog_a = 0;
    // Last bounce clears the count at edge 8; four clean samples land the press at edge 12.
    pabs = t0 + 13;
    rabs = t0 + 26;
    expect_burst(pabs, rabs, na);
    for (int i = 0; i < 10; i++) begin
      b_raw = pat[i];
      wait_cnt(t0 + i + 1);
    end
    b_raw = 1'b1;
    wait_cnt(pabs - 1);
    check("bounce_pressed_pre", {31'd0, if_a.PRESSED}, 0);
    wait_cnt(pabs);
    check("bounce_pressed_p", {31'd0, if_a.PRESSED}, 1);
    wait_cnt(t0 + 20);
    b_raw = 1'b0;
    finish_scn("bounce", rabs, na, 1, ca0, cb0);
    check("bounce_toggles", tog_a, 2);
  endtask

  task automatic run_reset_mid_repeat();
    int t0, n, na1, na2;
    logic [9:0] ca0, cb0;
    ca0 = cnt_a;
    cb0 = cnt_b;
    @(negedge clk);
    t0    = edge_cnt;
    b_raw = 1'b1;
    // Reset lands while the third pulse (after relative edge 16) is high.
    expect_burst(t0 + DEB + 2, t0 + 17, na1);
    while (edge_cnt < t0 + 17) begin
      @(posedge clk);
      #1;
    end
    check("rst_state_a_repeat", {30'd0, if_a.dbg_state}, 2);
    check("rst_c_before", {31'd0, if_a.C}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_c_async", {31'd0, if_a.C}, 0);
    check("rst_pressed_a_async", {31'd0, if_a.PRESSED}, 0);
    check("rst_pressed_b_async", {31'd0, if_b.PRESSED}, 0);
    check("rst_state_a_async", {30'd0, if_a.dbg_state}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = edge_cnt;
    expect_burst(n + DEB + 2, n + 16, na2);
    wait_cnt(n + DEB + 1);
    check("rst_repress_pre", {31'd0, if_a.PRESSED}, 0);
    wait_cnt(n + DEB + 2);
    check("rst_repress_p", {31'd0, if_a.PRESSED}, 1);
    wait_cnt(n + 10);
    b_raw = 1'b0;
    finish_scn("rst", n + 16, na1 + na2, 2, ca0, cb0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    check("reset_pressed_a", {31'd0, if_a.PRESSED}, 0);
    check("reset_c_a", {31'd0, if_a.C}, 0);
    check("reset_c_b", {31'd0, if_b.C}, 0);
    check("reset_state_a", {30'd0, if_a.dbg_state}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat ($urandom_range(2, 5)) @(negedge clk);
    check("idle_c_a", {31'd0, if_a.C}, 0);

    run_hold("short", 10);      // press 5, repeat 13, release 15
    repeat ($urandom_range(2, 6)) @(negedge clk);
    run_bounce();
    repeat ($urandom_range(2, 6)) @(negedge clk);
    run_hold("repeat", 40);     // 12 pulses on the repeating instance
    repeat ($urandom_range(2, 6)) @(negedge clk);
    run_hold("norep", 105);     // single pulse on the non-repeating instance
    repeat ($urandom_range(2, 6)) @(negedge clk);
    run_reset_mid_repeat();
    repeat ($urandom_range(2, 6)) @(negedge clk);
    run_hold("collide", 8);     // release lands on P+8: no repeat pulse

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
